dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] DMEM_DATA_SEG_BASE = 32'h1001_0000;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: combinational read, byte-enabled synchronous write.
module dmem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: storage has no reset on purpose; clearing a RAM on reset prevents block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Target side of the CPU load/store port: handshaked requests, WAIT_STATES wait cycles, error responses.
// Define DMEM_ALIGN_CHECK_EN to reject accesses with req_addr[1:0] != 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_DATA_SEG_BASE,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [3:0]  WS_M1 = WS - 4'd1;

  dmem_state_t   r_state;
  dmem_state_t   w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rdata;
  logic          r_rsp_err;

  logic [31:0]   w_offset;
  logic          w_req_err;
  logic          w_accept;
  logic          w_from_idle;
  logic          w_do_access;
  logic          w_acc_we;
  logic [AW-1:0] w_acc_idx;
  logic [31:0]   w_acc_wdata;
  logic [3:0]    w_acc_be;
  logic [31:0]   w_mem_rdata;

  // Range check on the offset avoids overflow of BASE_ADDR + span near the top of memory.
  assign w_offset = req_addr - BASE_ADDR;
  assign w_accept = req_valid && r_req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_req_err = (req_addr < BASE_ADDR) || ({1'b0, w_offset} >= SPAN) ||
                     (req_addr[1:0] != 2'b00);
`else
  assign w_req_err = (req_addr < BASE_ADDR) || ({1'b0, w_offset} >= SPAN);
`endif

  // With no wait states the access happens on the acceptance edge from the live request.
  assign w_from_idle = (r_state == IDLE);
  assign w_acc_we    = w_from_idle ? req_we            : r_we;
  assign w_acc_idx   = w_from_idle ? w_offset[AW+1:2]  : r_idx;
  assign w_acc_wdata = w_from_idle ? req_wdata         : r_wdata;
  assign w_acc_be    = w_from_idle ? req_be            : r_be;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    w_do_access = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_next = RESP;
          end else if (WS == 4'd0) begin
            w_next      = RESP;
            w_do_access = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next      = RESP;
          w_do_access = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset aborts an access that has not yet reached RESP, so the write never commits.
    if (!rst) begin
      w_next      = IDLE;
      w_do_access = 1'b0;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (w_do_access && w_acc_we),
    .be    (w_acc_be),
    .waddr (w_acc_idx),
    .raddr (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);

      if (w_accept) begin
        r_we    <= req_we;
        r_idx   <= w_offset[AW+1:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end

      if (w_next == WAIT && r_state == IDLE) begin
        r_cnt <= WS_M1;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_do_access) begin
        r_rdata   <= w_acc_we ? 32'd0 : w_mem_rdata;
        r_rsp_err <= 1'b0;
      end else if (r_state == IDLE && w_accept && w_req_err) begin
        r_rdata   <= 32'd0;
        r_rsp_err <= 1'b1;
      end else if (r_state == RESP && rsp_ready) begin
        r_rdata   <= 32'd0;
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int          W     = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    bit e;
    e = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + longint'(DEPTH) * 4);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_rd(input int idx);
    return mdl.exists(idx) ? mdl[idx] : 32'd0;
  endfunction

  // stall < 0: rsp_ready held high; otherwise rsp_ready stays low for 'stall' cycles in RESP.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall);
    bit          e;
    int          idx;
    int          lat;
    logic [31:0] exp_rd;
    logic [31:0] w;
    e      = addr_err(addr);
    idx    = int'((addr - BASE) >> 2);
    exp_rd = 32'd0;
    if (!e) begin
      if (we) begin
        w = model_rd(idx);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mdl[idx] = w;
      end else begin
        exp_rd = model_rd(idx);
      end
    end

    @(negedge clk);
    check({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (stall < 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, e ? 1 : 1 + W);
    check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, e});
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);

    if (stall >= 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        check({tag, ".stall"}, {rsp_valid, req_ready, rsp_err, rsp_rdata[28:0]},
              {1'b1, 1'b0, e, exp_rd[28:0]});
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".outs"}, {req_ready, rsp_valid, rsp_err, rsp_rdata[28:0]}, 32'h8000_0000);
    check({tag, ".rdata_hi"}, {29'd0, rsp_rdata[31:29]}, 32'd0);
  endtask

  initial begin
    bit          we;
    logic [31:0] addr;
    int          lat;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    txn("st_cafe", 1'b1, BASE + 32'h8, 32'hCAFE_F00D, 4'hF, -1);
    txn("ld_cafe", 1'b0, BASE + 32'h8, 32'h0, 4'h0, -1);

    txn("st_1122", 1'b1, BASE, 32'h1122_3344, 4'hF, 0);
    txn("st_ab",   1'b1, BASE, 32'h0000_00AB, 4'b0001, 1);
    txn("ld_ab",   1'b0, BASE, 32'h0, 4'h0, 0);
    txn("st_be0",  1'b1, BASE, 32'hFFFF_FFFF, 4'b0000, -1);
    txn("ld_be0",  1'b0, BASE, 32'h0, 4'hF, -1);

    txn("err_lo",  1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0);
    txn("err_hi",  1'b0, 32'h1001_1000, 32'h0, 4'h0, -1);
    txn("err_st",  1'b1, 32'h1001_1000, 32'h1234_5678, 4'hF, -1);
    txn("st_top",  1'b1, 32'h1001_0FFC, 32'hA5A5_5A5A, 4'hF, -1);
    txn("ld_top",  1'b0, 32'h1001_0FFC, 32'h0, 4'h0, -1);
    txn("ld_mis",  1'b0, 32'h1001_0002, 32'h0, 4'h0, -1);
    txn("stall5",  1'b0, BASE + 32'h8, 32'h0, 4'h0, 5);

    // Reset while a store is still waiting: the store must not land.
    txn("st_old",  1'b1, BASE + 32'h40, 32'h55AA_55AA, 4'hF, -1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40;
    req_wdata = 32'hDEAD_BEEF; req_be = 4'hF; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_wait");
    rst = 1'b1;
    rsp_ready = 1'b0;
    txn("ld_old",  1'b0, BASE + 32'h40, 32'h0, 4'h0, -1);

    // Reset once the store has reached RESP: the store stays committed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h44;
    req_wdata = 32'h0BAD_F00D; req_be = 4'hF; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_resp.latency", lat, 1 + W);
    mdl[17] = 32'h0BAD_F00D;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_resp");
    rst = 1'b1;
    txn("ld_new",  1'b0, BASE + 32'h44, 32'h0, 4'h0, 0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'(4 * $urandom_range(1, 4));
        1:       addr = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
        default: begin
          addr = BASE + 32'(4 * (($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                                              : DEPTH - 8 + $urandom_range(0, 7)));
          if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        end
      endcase
      we = 1'($urandom_range(0, 1));
      txn($sformatf("rnd%0d", n), we, addr, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
